// File: rtl/rx_port_arbiter.sv
// rx_port_arbiter: round-robin merge of several RX beat streams onto one
// parser chain that cannot apply backpressure. A port keeps the grant for a
// whole packet. A packet that stalls too long mid-flight is truncated: an
// abort marker goes downstream, and the rest of that packet is swallowed.
//
// Handshake: source port i hands over a beat on a rising edge where
// s_valid[i] && s_ready[i]. s_ready depends only on registered state, never
// on s_valid. The master side has no ready: every m_valid cycle is consumed.
//
// dbg_state encoding: 0 = IDLE, 1 = FWD, 2 = DRAIN.
module rx_port_arbiter #(
   parameter  int DATA_WIDTH = 64,
   parameter  int NUM_PORTS  = 2,
   parameter  int TIMEOUT    = 256,
   localparam int IW         = $clog2(DATA_WIDTH/8+1),
   localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_PORTS*IW-1:0]         s_idx,
   input  logic [NUM_PORTS-1:0]            s_valid,
   input  logic [NUM_PORTS-1:0]            s_last,
   output logic [NUM_PORTS-1:0]            s_ready,
   output logic [DATA_WIDTH-1:0]           m_tdata,
   output logic [IW-1:0]                   m_idx,
   output logic                            m_valid,
   output logic                            m_last,
   output logic [PW-1:0]                   m_port,
   output logic                            m_abort,
   output logic [15:0]                     abort_cnt,
   output logic [1:0]                      dbg_state
);

   // Idle counter only has to reach TIMEOUT; one bit is enough when disabled.
   localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
   localparam bit            TO_EN  = (TIMEOUT > 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FWD   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                state_q;
   logic [PW-1:0]         grant_q;
   logic [PW-1:0]         last_grant_q;
   logic [CW-1:0]         cnt_q;
   logic [15:0]           abort_cnt_q;
   logic [DATA_WIDTH-1:0] m_tdata_q;
   logic [IW-1:0]         m_idx_q;
   logic                  m_valid_q;
   logic                  m_last_q;
   logic [PW-1:0]         m_port_q;
   logic                  m_abort_q;

   logic                  arb_found;
   logic [PW-1:0]         arb_sel;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [IW-1:0]         sel_idx;
   logic                  sel_valid;
   logic                  sel_last;
   logic                  beat_acc;
   logic [CW-1:0]         cnt_inc;

   // Round-robin pick: first requester after last_grant, wrapping around.
   always_comb begin
      arb_found = 1'b0;
      arb_sel   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!arb_found && (i == (int'(last_grant_q) + k) % NUM_PORTS) && s_valid[i]) begin
               arb_found = 1'b1;
               arb_sel   = PW'(i);
            end
         end
      end
   end

   // Select the granted port's beat fields.
   always_comb begin
      sel_data  = '0;
      sel_idx   = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_q == PW'(i)) begin
            sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_idx   = s_idx[i*IW +: IW];
            sel_valid = s_valid[i];
            sel_last  = s_last[i];
         end
      end
   end

   // Only the granted port is ready, and only while a packet is open.
   always_comb begin
      s_ready = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         s_ready[i] = (state_q != ST_IDLE) && (grant_q == PW'(i));
      end
   end

   assign beat_acc = (state_q != ST_IDLE) && sel_valid;
   assign cnt_inc  = cnt_q + CW'(1);

   // Arbitration/forwarding FSM with all downstream outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= PW'(NUM_PORTS-1);
         cnt_q        <= '0;
         abort_cnt_q  <= '0;
         m_tdata_q    <= '0;
         m_idx_q      <= '0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         m_port_q     <= '0;
         m_abort_q    <= 1'b0;
      end else begin
         // Strobes are single-cycle; data, idx and port hold between beats.
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_abort_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Arbitration costs this cycle; nothing is accepted yet.
               if (arb_found) begin
                  grant_q <= arb_sel;
                  cnt_q   <= '0;
                  state_q <= ST_FWD;
               end
            end
            ST_FWD: begin
               if (beat_acc) begin
                  // An accepted beat always wins over a pending timeout.
                  m_tdata_q <= sel_data;
                  m_idx_q   <= sel_idx;
                  m_last_q  <= sel_last;
                  m_valid_q <= 1'b1;
                  m_port_q  <= grant_q;
                  cnt_q     <= '0;
                  if (sel_last) begin
                     last_grant_q <= grant_q;
                     state_q      <= ST_IDLE;
                  end
               end else if (TO_EN) begin
                  if (cnt_inc == TO_VAL) begin
                     // Close the packet downstream with an empty last marker.
                     m_abort_q <= 1'b1;
                     m_last_q  <= 1'b1;
                     m_idx_q   <= '0;
                     m_port_q  <= grant_q;
                     cnt_q     <= '0;
                     state_q   <= ST_DRAIN;
                     if (abort_cnt_q != 16'hFFFF) begin
                        abort_cnt_q <= abort_cnt_q + 16'd1;
                     end
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            ST_DRAIN: begin
               // Swallow the remainder of the truncated packet; no timeout here.
               if (beat_acc && sel_last) begin
                  last_grant_q <= grant_q;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_tdata   = m_tdata_q;
   assign m_idx     = m_idx_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign m_port    = m_port_q;
   assign m_abort   = m_abort_q;
   assign abort_cnt = abort_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_rx_port_arbiter.sv
// Directed bench for rx_port_arbiter: two ports, TIMEOUT 4. Inputs change
// on the falling edge; outputs are sampled on the falling edge.
module tb_rx_port_arbiter;

   localparam int DW = 64;
   localparam int NP = 2;
   localparam int TO = 4;
   localparam int IW = 4;
   localparam int PW = 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NP*DW-1:0] s_tdata = '0;
   logic [NP*IW-1:0] s_idx = '0;
   logic [NP-1:0]    s_valid = '0;
   logic [NP-1:0]    s_last = '0;
   logic [NP-1:0]    s_ready;
   logic [DW-1:0]    m_tdata;
   logic [IW-1:0]    m_idx;
   logic             m_valid;
   logic             m_last;
   logic [PW-1:0]    m_port;
   logic             m_abort;
   logic [15:0]      abort_cnt;
   logic [1:0]       dbg_state;

   int tests_run = 0;
   int tests_failed = 0;

   rx_port_arbiter #(
      .DATA_WIDTH(DW),
      .NUM_PORTS (NP),
      .TIMEOUT   (TO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_tdata  (s_tdata),
      .s_idx    (s_idx),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_tdata  (m_tdata),
      .m_idx    (m_idx),
      .m_valid  (m_valid),
      .m_last   (m_last),
      .m_port   (m_port),
      .m_abort  (m_abort),
      .abort_cnt(abort_cnt),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_beat(input int p, input logic [DW-1:0] d, input logic [IW-1:0] n, input logic l);
      s_tdata[p*DW +: DW] = d;
      s_idx[p*IW +: IW]   = n;
      s_last[p]           = l;
      s_valid[p]          = 1'b1;
   endtask

   task automatic drop(input int p);
      s_valid[p] = 1'b0;
      s_last[p]  = 1'b0;
   endtask

   function automatic logic [DW-1:0] mk(input int p, input int n, input int b);
      return 64'hC0DE_0000_0000_0000 | (64'(p) << 16) | (64'(n) << 8) | 64'(b);
   endfunction

   // scenario tasks
   task automatic test_reset();
      rst_n   = 1'b0;
      s_valid = '0;
      s_last  = '0;
      repeat (2) tick();
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %0h want 0", m_valid); end
      tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL reset_m_last: got %0h want 0", m_last); end
      tests_run++; if (m_abort !== 1'b0) begin tests_failed++; $display("FAIL reset_m_abort: got %0h want 0", m_abort); end
      tests_run++; if (m_tdata !== 64'h0) begin tests_failed++; $display("FAIL reset_m_tdata: got %0h want 0", m_tdata); end
      tests_run++; if (m_idx !== 4'h0) begin tests_failed++; $display("FAIL reset_m_idx: got %0h want 0", m_idx); end
      tests_run++; if (m_port !== 1'b0) begin tests_failed++; $display("FAIL reset_m_port: got %0h want 0", m_port); end
      tests_run++; if (abort_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_abort_cnt: got %0h want 0", abort_cnt); end
      tests_run++; if (s_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_s_ready: got %0b want 00", s_ready); end
      tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_packet();
      tick();
      drive_beat(0, 64'h1111_0000_0000_00A0, 4'd8, 1'b0);
      tick();
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL single_arb_m_valid: got %0h want 0", m_valid); end
      tests_run++; if (s_ready !== 2'b01) begin tests_failed++; $display("FAIL single_s_ready: got %0b want 01", s_ready); end
      tests_run++; if (dbg_state !== 2'd1) begin tests_failed++; $display("FAIL single_state_fwd: got %0d want 1", dbg_state); end
      tick();
      tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL single_b0_valid: got %0h want 1", m_valid); end
      tests_run++; if (m_tdata !== 64'h1111_0000_0000_00A0) begin tests_failed++; $display("FAIL single_b0_data: got %0h want 11110000000000a0", m_tdata); end
      tests_run++; if (m_idx !== 4'd8) begin tests_failed++; $display("FAIL single_b0_idx: got %0d want 8", m_idx); end
      tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL single_b0_last: got %0h want 0", m_last); end
      tests_run++; if (m_port !== 1'b0) begin tests_failed++; $display("FAIL single_b0_port: got %0h want 0", m_port); end
      drive_beat(0, 64'h1111_0000_0000_00A1, 4'd8, 1'b0);
      tick();
      tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL single_b1_valid: got %0h want 1", m_valid); end
      tests_run++; if (m_tdata !== 64'h1111_0000_0000_00A1) begin tests_failed++; $display("FAIL single_b1_data: got %0h want 11110000000000a1", m_tdata); end
      tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL single_b1_last: got %0h want 0", m_last); end
      drive_beat(0, 64'h1111_0000_0000_00A2, 4'd6, 1'b1);
      tick();
      tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL single_b2_valid: got %0h want 1", m_valid); end
      tests_run++; if (m_tdata !== 64'h1111_0000_0000_00A2) begin tests_failed++; $display("FAIL single_b2_data: got %0h want 11110000000000a2", m_tdata); end
      tests_run++; if (m_idx !== 4'd6) begin tests_failed++; $display("FAIL single_b2_idx: got %0d want 6", m_idx); end
      tests_run++; if (m_last !== 1'b1) begin tests_failed++; $display("FAIL single_b2_last: got %0h want 1", m_last); end
      tests_run++; if (s_ready !== 2'b00) begin tests_failed++; $display("FAIL single_idle_ready: got %0b want 00", s_ready); end
      drop(0);
      tick();
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL single_after_valid: got %0h want 0", m_valid); end
      tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL single_after_last: got %0h want 0", m_last); end
      tests_run++; if (m_tdata !== 64'h1111_0000_0000_00A2) begin tests_failed++; $display("FAIL single_hold_data: got %0h want 11110000000000a2", m_tdata); end
      tests_run++; if (m_idx !== 4'd6) begin tests_failed++; $display("FAIL single_hold_idx: got %0d want 6", m_idx); end
   endtask

   task automatic test_round_robin();
      int pcnt[2];
      int bt[2];
      logic [1:0] acc;
      int pkt;
      int pp;
      int b;
      logic exp_mv;
      pcnt = '{0, 0};
      bt   = '{0, 0};
      acc  = 2'b00;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         tick();
         if (k > 0) begin
            exp_mv = ((k % 3) != 1);
            tests_run++; if (m_valid !== exp_mv) begin tests_failed++; $display("FAIL rr_valid_k%0d: got %0h want %0h", k, m_valid, exp_mv); end
            if (exp_mv) begin
               pkt = (k - 2) / 3;
               pp  = pkt % 2;
               b   = ((k % 3) == 2) ? 0 : 1;
               tests_run++; if (m_port !== 1'(pp)) begin tests_failed++; $display("FAIL rr_port_k%0d: got %0h want %0h", k, m_port, pp); end
               tests_run++; if (m_last !== (b == 1)) begin tests_failed++; $display("FAIL rr_last_k%0d: got %0h want %0h", k, m_last, (b == 1)); end
               tests_run++; if (m_tdata !== mk(pp, pkt / 2, b)) begin tests_failed++; $display("FAIL rr_data_k%0d: got %0h want %0h", k, m_tdata, mk(pp, pkt / 2, b)); end
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               bt[i]++;
               if (bt[i] == 2) begin
                  bt[i] = 0;
                  pcnt[i]++;
               end
            end
         end
         if (k < 12) begin
            for (int i = 0; i < 2; i++) drive_beat(i, mk(i, pcnt[i], bt[i]), 4'd8, (bt[i] == 1));
         end else begin
            drop(0);
            drop(1);
         end
         acc = s_valid & s_ready;
      end
   endtask

   task automatic test_timeout();
      tick();
      drive_beat(1, 64'hB0, 4'd8, 1'b0);
      tick();
      tests_run++; if (s_ready !== 2'b10) begin tests_failed++; $display("FAIL to_s_ready: got %0b want 10", s_ready); end
      tick();
      tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL to_beat_valid: got %0h want 1", m_valid); end
      tests_run++; if (m_port !== 1'b1) begin tests_failed++; $display("FAIL to_beat_port: got %0h want 1", m_port); end
      drop(1);
      for (int s = 1; s <= 3; s++) begin
         tick();
         tests_run++; if (m_abort !== 1'b0) begin tests_failed++; $display("FAIL to_early_abort_s%0d: got %0h want 0", s, m_abort); end
      end
      tick();
      tests_run++; if (m_abort !== 1'b1) begin tests_failed++; $display("FAIL to_abort: got %0h want 1", m_abort); end
      tests_run++; if (m_last !== 1'b1) begin tests_failed++; $display("FAIL to_abort_last: got %0h want 1", m_last); end
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL to_abort_valid: got %0h want 0", m_valid); end
      tests_run++; if (m_idx !== 4'd0) begin tests_failed++; $display("FAIL to_abort_idx: got %0d want 0", m_idx); end
      tests_run++; if (m_port !== 1'b1) begin tests_failed++; $display("FAIL to_abort_port: got %0h want 1", m_port); end
      tests_run++; if (abort_cnt !== 16'd1) begin tests_failed++; $display("FAIL to_abort_cnt: got %0d want 1", abort_cnt); end
      tests_run++; if (dbg_state !== 2'd2) begin tests_failed++; $display("FAIL to_state_drain: got %0d want 2", dbg_state); end
      drive_beat(1, 64'hB1, 4'd8, 1'b0);
      drive_beat(0, 64'hE5, 4'd3, 1'b1);
      tick();
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL to_drain_valid: got %0h want 0", m_valid); end
      tests_run++; if (m_abort !== 1'b0) begin tests_failed++; $display("FAIL to_abort_pulse: got %0h want 0", m_abort); end
      tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL to_drain_last: got %0h want 0", m_last); end
      tests_run++; if (s_ready !== 2'b10) begin tests_failed++; $display("FAIL to_drain_ready: got %0b want 10", s_ready); end
      drive_beat(1, 64'hB2, 4'd8, 1'b1);
      tick();
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL to_drain_last_valid: got %0h want 0", m_valid); end
      tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL to_back_idle: got %0d want 0", dbg_state); end
      tests_run++; if (m_tdata !== 64'hB0) begin tests_failed++; $display("FAIL to_hold_data: got %0h want b0", m_tdata); end
      tests_run++; if (abort_cnt !== 16'd1) begin tests_failed++; $display("FAIL to_cnt_hold: got %0d want 1", abort_cnt); end
      drop(1);
      tick();
      tests_run++; if (s_ready !== 2'b01) begin tests_failed++; $display("FAIL to_next_grant: got %0b want 01", s_ready); end
      tick();
      tests_run++; if (m_valid !== 1'b1 || m_port !== 1'b0 || m_last !== 1'b1 || m_tdata !== 64'hE5) begin
         tests_failed++; $display("FAIL to_next_pkt: got v%0h p%0h l%0h d%0h want v1 p0 l1 de5", m_valid, m_port, m_last, m_tdata);
      end
      drop(0);
   endtask

   task automatic test_stall_boundary();
      tick();
      drive_beat(0, 64'hC0, 4'd5, 1'b0);
      tick();
      tick();
      tests_run++; if (m_valid !== 1'b1 || m_idx !== 4'd5) begin tests_failed++; $display("FAIL sb_first: got v%0h i%0d want v1 i5", m_valid, m_idx); end
      drop(0);
      tick();
      tick();
      tick();
      drive_beat(0, 64'hC1, 4'd0, 1'b0);
      tick();
      tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL sb_win_valid: got %0h want 1", m_valid); end
      tests_run++; if (m_abort !== 1'b0) begin tests_failed++; $display("FAIL sb_win_abort: got %0h want 0", m_abort); end
      tests_run++; if (m_idx !== 4'd0) begin tests_failed++; $display("FAIL sb_idx0: got %0d want 0", m_idx); end
      tests_run++; if (m_tdata !== 64'hC1) begin tests_failed++; $display("FAIL sb_data: got %0h want c1", m_tdata); end
      tests_run++; if (abort_cnt !== 16'd1) begin tests_failed++; $display("FAIL sb_cnt_same: got %0d want 1", abort_cnt); end
      drop(0);
      for (int s = 1; s <= 3; s++) begin
         tick();
         tests_run++; if (m_abort !== 1'b0) begin tests_failed++; $display("FAIL sb_restart_s%0d: got %0h want 0", s, m_abort); end
      end
      tick();
      tests_run++; if (m_abort !== 1'b1) begin tests_failed++; $display("FAIL sb_late_abort: got %0h want 1", m_abort); end
      tests_run++; if (abort_cnt !== 16'd2) begin tests_failed++; $display("FAIL sb_cnt2: got %0d want 2", abort_cnt); end
      tests_run++; if (m_port !== 1'b0) begin tests_failed++; $display("FAIL sb_abort_port: got %0h want 0", m_port); end
      drive_beat(0, 64'hC2, 4'd8, 1'b1);
      tick();
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL sb_discard: got %0h want 0", m_valid); end
      tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL sb_idle: got %0d want 0", dbg_state); end
      drop(0);
   endtask

   task automatic test_reset_mid_packet();
      tick();
      drive_beat(1, 64'hD0, 4'd8, 1'b0);
      tick();
      tick();
      tests_run++; if (m_valid !== 1'b1 || m_port !== 1'b1) begin tests_failed++; $display("FAIL rm_beat: got v%0h p%0h want v1 p1", m_valid, m_port); end
      drive_beat(1, 64'hD1, 4'd8, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_valid: got %0h want 0", m_valid); end
      tests_run++; if (m_tdata !== 64'h0) begin tests_failed++; $display("FAIL rm_data: got %0h want 0", m_tdata); end
      tests_run++; if (m_idx !== 4'd0) begin tests_failed++; $display("FAIL rm_idx: got %0d want 0", m_idx); end
      tests_run++; if (m_port !== 1'b0) begin tests_failed++; $display("FAIL rm_port: got %0h want 0", m_port); end
      tests_run++; if (s_ready !== 2'b00) begin tests_failed++; $display("FAIL rm_ready: got %0b want 00", s_ready); end
      tests_run++; if (abort_cnt !== 16'd0) begin tests_failed++; $display("FAIL rm_cnt: got %0d want 0", abort_cnt); end
      tests_run++; if (m_last !== 1'b0 || m_abort !== 1'b0) begin tests_failed++; $display("FAIL rm_flags: got l%0h a%0h want l0 a0", m_last, m_abort); end
      tick();
      rst_n = 1'b1;
      drive_beat(0, 64'hE0, 4'd8, 1'b1);
      drive_beat(1, 64'hE1, 4'd8, 1'b1);
      tick();
      tests_run++; if (s_ready !== 2'b01) begin tests_failed++; $display("FAIL rm_first_grant: got %0b want 01", s_ready); end
      tick();
      tests_run++; if (m_valid !== 1'b1 || m_port !== 1'b0 || m_tdata !== 64'hE0 || m_abort !== 1'b0) begin
         tests_failed++; $display("FAIL rm_p0_pkt: got v%0h p%0h d%0h a%0h want v1 p0 de0 a0", m_valid, m_port, m_tdata, m_abort);
      end
      drop(0);
      tick();
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_gap: got %0h want 0", m_valid); end
      tick();
      tests_run++; if (m_valid !== 1'b1 || m_port !== 1'b1 || m_tdata !== 64'hE1 || m_last !== 1'b1) begin
         tests_failed++; $display("FAIL rm_p1_pkt: got v%0h p%0h d%0h l%0h want v1 p1 de1 l1", m_valid, m_port, m_tdata, m_last);
      end
      drop(1);
      tick();
   endtask

   // sequence and final report
   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_timeout();
      test_stall_boundary();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
